// File: rtl/clock_time_keeper.sv
// Alarm-clock time-of-day and alarm registers: 12-hour minute counter driven by a seconds
// strobe, plus a user-programmable alarm time, both editable through set/advance buttons.
module clock_time_keeper #(
    parameter int unsigned TICKS_PER_MIN = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sec_tick,
    input  logic       i_set_time,
    input  logic       i_set_alarm,
    input  logic       i_adv_hour,
    input  logic       i_adv_min,
    output logic [3:0] o_time_hours,
    output logic [5:0] o_time_mins,
    output logic       o_time_am_pm,
    output logic [3:0] o_alarm_hours,
    output logic [5:0] o_alarm_mins,
    output logic       o_alarm_am_pm,
    output logic       o_min_tick
);

    localparam int unsigned SecW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [SecW-1:0] SecLast = SecW'(TICKS_PER_MIN - 1);

    typedef enum logic [1:0] {
        ModeRun,
        ModeSetTime,
        ModeSetAlarm
    } mode_e;

    // Returns {am_pm, hours} after one step of the 12-hour sequence.
    function automatic logic [4:0] f_hour_adv(input logic [3:0] hours, input logic am_pm);
        logic [4:0] res;
        if (hours == 4'd11) begin
            res = {~am_pm, 4'd12};
        end else if (hours >= 4'd12 || hours == 4'd0) begin
            res = {am_pm, 4'd1};
        end else begin
            res = {am_pm, hours + 4'd1};
        end
        return res;
    endfunction

    function automatic logic [5:0] f_min_inc(input logic [5:0] mins);
        return (mins >= 6'd59) ? 6'd0 : mins + 6'd1;
    endfunction

    logic [SecW-1:0] r_sec_cnt;
    logic [3:0]      r_time_hours;
    logic [5:0]      r_time_mins;
    logic            r_time_am_pm;
    logic [3:0]      r_alarm_hours;
    logic [5:0]      r_alarm_mins;
    logic            r_alarm_am_pm;
    logic            r_min_tick;

    mode_e           w_mode;
    logic            w_rollover;
    logic [SecW-1:0] w_sec_cnt;
    logic [3:0]      w_time_hours;
    logic [5:0]      w_time_mins;
    logic            w_time_am_pm;
    logic [3:0]      w_alarm_hours;
    logic [5:0]      w_alarm_mins;
    logic            w_alarm_am_pm;

    // set_time outranks set_alarm, so the alarm can never be edited while the time is.
    always_comb begin
        if (i_set_time) begin
            w_mode = ModeSetTime;
        end else if (i_set_alarm) begin
            w_mode = ModeSetAlarm;
        end else begin
            w_mode = ModeRun;
        end
    end

    assign w_rollover = (w_mode != ModeSetTime) && i_sec_tick && (r_sec_cnt >= SecLast);

    // Holding the counter at zero in set-time mode makes the first minute after release full length.
    always_comb begin
        w_sec_cnt = r_sec_cnt;
        if (w_mode == ModeSetTime) begin
            w_sec_cnt = '0;
        end else if (i_sec_tick) begin
            w_sec_cnt = w_rollover ? '0 : r_sec_cnt + SecW'(1);
        end
    end

    always_comb begin
        w_time_hours = r_time_hours;
        w_time_mins  = r_time_mins;
        w_time_am_pm = r_time_am_pm;
        if (w_mode == ModeSetTime) begin
            if (i_adv_min) begin
                w_time_mins = f_min_inc(r_time_mins);
            end
            if (i_adv_hour) begin
                {w_time_am_pm, w_time_hours} = f_hour_adv(r_time_hours, r_time_am_pm);
            end
        end else if (w_rollover) begin
            w_time_mins = f_min_inc(r_time_mins);
            if (r_time_mins >= 6'd59) begin
                {w_time_am_pm, w_time_hours} = f_hour_adv(r_time_hours, r_time_am_pm);
            end
        end
    end

    always_comb begin
        w_alarm_hours = r_alarm_hours;
        w_alarm_mins  = r_alarm_mins;
        w_alarm_am_pm = r_alarm_am_pm;
        if (w_mode == ModeSetAlarm) begin
            if (i_adv_min) begin
                w_alarm_mins = f_min_inc(r_alarm_mins);
            end
            if (i_adv_hour) begin
                {w_alarm_am_pm, w_alarm_hours} = f_hour_adv(r_alarm_hours, r_alarm_am_pm);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_cnt     <= '0;
            r_time_hours  <= 4'd12;
            r_time_mins   <= 6'd0;
            r_time_am_pm  <= 1'b0;
            r_alarm_hours <= 4'd6;
            r_alarm_mins  <= 6'd0;
            r_alarm_am_pm <= 1'b0;
            r_min_tick    <= 1'b0;
        end else begin
            r_sec_cnt     <= w_sec_cnt;
            r_time_hours  <= w_time_hours;
            r_time_mins   <= w_time_mins;
            r_time_am_pm  <= w_time_am_pm;
            r_alarm_hours <= w_alarm_hours;
            r_alarm_mins  <= w_alarm_mins;
            r_alarm_am_pm <= w_alarm_am_pm;
            r_min_tick    <= w_rollover;
        end
    end

    assign o_time_hours  = r_time_hours;
    assign o_time_mins   = r_time_mins;
    assign o_time_am_pm  = r_time_am_pm;
    assign o_alarm_hours = r_alarm_hours;
    assign o_alarm_mins  = r_alarm_mins;
    assign o_alarm_am_pm = r_alarm_am_pm;
    assign o_min_tick    = r_min_tick;

    a_time_hours_legal : assert property (@(posedge clk) disable iff (!rst_n)
        r_time_hours >= 4'd1 && r_time_hours <= 4'd12);
    a_alarm_hours_legal : assert property (@(posedge clk) disable iff (!rst_n)
        r_alarm_hours >= 4'd1 && r_alarm_hours <= 4'd12);
    a_mins_legal : assert property (@(posedge clk) disable iff (!rst_n)
        r_time_mins <= 6'd59 && r_alarm_mins <= 6'd59);

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed bench for clock_time_keeper with TICKS_PER_MIN = 4: a vector table for the
// single-cycle behaviour plus hand-written presets and an asynchronous mid-edit reset.
module tb_clock_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_sec_tick, i_set_time, i_set_alarm, i_adv_hour, i_adv_min;
    logic [3:0] o_time_hours, o_alarm_hours;
    logic [5:0] o_time_mins, o_alarm_mins;
    logic       o_time_am_pm, o_alarm_am_pm, o_min_tick;

    int n_checks = 0;
    int n_fail   = 0;

    clock_time_keeper #(.TICKS_PER_MIN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sec_tick   (i_sec_tick),
        .i_set_time   (i_set_time),
        .i_set_alarm  (i_set_alarm),
        .i_adv_hour   (i_adv_hour),
        .i_adv_min    (i_adv_min),
        .o_time_hours (o_time_hours),
        .o_time_mins  (o_time_mins),
        .o_time_am_pm (o_time_am_pm),
        .o_alarm_hours(o_alarm_hours),
        .o_alarm_mins (o_alarm_mins),
        .o_alarm_am_pm(o_alarm_am_pm),
        .o_min_tick   (o_min_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, sa, tk, ah, am;
        logic [3:0] th;
        logic [5:0] tm;
        logic       tap;
        logic [3:0] alh;
        logic [5:0] alm;
        logic       alap;
        logic       mt;
    } vec_t;

    vec_t vecs [0:30];

    task automatic row(input int idx, input logic st, sa, tk, ah, am,
                       input int th, tm, input logic tap, input int alh, alm,
                       input logic alap, mt);
        vecs[idx] = '{st, sa, tk, ah, am, 4'(th), 6'(tm), tap, 4'(alh), 6'(alm), alap, mt};
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int th, tm, tap, alh, alm, alap, mt);
        chk({tag, " time_hours"}, int'(o_time_hours), th);
        chk({tag, " time_mins"}, int'(o_time_mins), tm);
        chk({tag, " time_am_pm"}, int'(o_time_am_pm), tap);
        chk({tag, " alarm_hours"}, int'(o_alarm_hours), alh);
        chk({tag, " alarm_mins"}, int'(o_alarm_mins), alm);
        chk({tag, " alarm_am_pm"}, int'(o_alarm_am_pm), alap);
        chk({tag, " min_tick"}, int'(o_min_tick), mt);
    endtask

    // One clock cycle: levels persist, pulses are cleared just after the sampling edge.
    task automatic cyc(input logic st, sa, tk, ah, am);
        i_set_time  = st;
        i_set_alarm = sa;
        i_sec_tick  = tk;
        i_adv_hour  = ah;
        i_adv_min   = am;
        @(posedge clk);
        #1;
        i_sec_tick = 1'b0;
        i_adv_hour = 1'b0;
        i_adv_min  = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cyc(vecs[i].st, vecs[i].sa, vecs[i].tk, vecs[i].ah, vecs[i].am);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].th), int'(vecs[i].tm),
                    int'(vecs[i].tap), int'(vecs[i].alh), int'(vecs[i].alm),
                    int'(vecs[i].alap), int'(vecs[i].mt));
        end
    endtask

    task automatic press(input logic st, sa, input int n_hour, input int n_min);
        for (int i = 0; i < n_hour; i++) cyc(st, sa, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < n_min; i++) cyc(st, sa, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        //      idx st sa tk ah am   th tm tap  alh alm alap mt
        row(0,  0, 0, 1, 0, 0,  12, 0, 0,   6, 0, 0, 0);
        row(1,  0, 0, 1, 0, 0,  12, 0, 0,   6, 0, 0, 0);
        row(2,  0, 0, 1, 0, 0,  12, 0, 0,   6, 0, 0, 0);
        row(3,  0, 0, 1, 0, 0,  12, 1, 0,   6, 0, 0, 1);
        row(4,  0, 0, 0, 0, 0,  12, 1, 0,   6, 0, 0, 0);
        row(5,  0, 0, 0, 1, 1,  12, 1, 0,   6, 0, 0, 0);
        row(6,  0, 0, 1, 0, 0,  11, 59, 0,  6, 0, 0, 0);
        row(7,  0, 0, 1, 0, 0,  11, 59, 0,  6, 0, 0, 0);
        row(8,  0, 0, 1, 0, 0,  11, 59, 0,  6, 0, 0, 0);
        row(9,  0, 0, 1, 0, 0,  12, 0, 1,   6, 0, 0, 1);
        row(10, 0, 0, 1, 0, 0,  12, 59, 1,  6, 0, 0, 0);
        row(11, 0, 0, 1, 0, 0,  12, 59, 1,  6, 0, 0, 0);
        row(12, 0, 0, 1, 0, 0,  12, 59, 1,  6, 0, 0, 0);
        row(13, 0, 0, 1, 0, 0,  1, 0, 1,    6, 0, 0, 1);
        row(14, 1, 0, 0, 0, 1,  3, 0, 1,    6, 0, 0, 0);
        row(15, 1, 0, 1, 0, 0,  3, 0, 1,    6, 0, 0, 0);
        row(16, 1, 0, 1, 0, 0,  3, 0, 1,    6, 0, 0, 0);
        row(17, 1, 0, 1, 0, 0,  3, 0, 1,    6, 0, 0, 0);
        row(18, 1, 0, 1, 0, 0,  3, 0, 1,    6, 0, 0, 0);
        row(19, 1, 1, 0, 1, 0,  4, 0, 1,    6, 0, 0, 0);
        row(20, 0, 1, 1, 1, 0,  4, 0, 1,    7, 0, 0, 0);
        row(21, 0, 1, 1, 1, 0,  4, 0, 1,    8, 0, 0, 0);
        row(22, 0, 1, 1, 1, 0,  4, 0, 1,    9, 0, 0, 0);
        row(23, 0, 1, 1, 1, 0,  4, 1, 1,   10, 0, 0, 1);
        row(24, 0, 1, 1, 1, 0,  4, 1, 1,   11, 0, 0, 0);
        row(25, 0, 1, 1, 1, 0,  4, 1, 1,   12, 0, 1, 0);
        row(26, 0, 0, 1, 0, 0,  4, 59, 1,   6, 0, 1, 0);
        row(27, 0, 0, 1, 0, 0,  4, 59, 1,   6, 0, 1, 0);
        row(28, 0, 0, 1, 0, 0,  4, 59, 1,   6, 0, 1, 0);
        row(29, 0, 1, 1, 0, 1,  5, 0, 1,    6, 1, 1, 1);
        row(30, 1, 0, 0, 1, 1,  12, 0, 1,   6, 1, 1, 0);

        rst_n = 1'b0;
        {i_sec_tick, i_set_time, i_set_alarm, i_adv_hour, i_adv_min} = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("reset", 12, 0, 0, 6, 0, 0, 0);

        run_rows(0, 5);

        press(1'b1, 1'b0, 11, 58);
        chk_all("preset 11:59AM", 11, 59, 0, 6, 0, 0, 0);
        run_rows(6, 9);

        press(1'b1, 1'b0, 0, 59);
        chk_all("preset 12:59PM", 12, 59, 1, 6, 0, 0, 0);
        run_rows(10, 13);

        press(1'b1, 1'b0, 2, 59);
        chk_all("preset 3:59PM", 3, 59, 1, 6, 0, 0, 0);
        run_rows(14, 25);

        press(1'b0, 1'b1, 6, 0);
        press(1'b1, 1'b0, 0, 58);
        chk_all("preset 4:59PM", 4, 59, 1, 6, 0, 1, 0);
        run_rows(26, 29);

        press(1'b1, 1'b0, 18, 59);
        chk_all("preset 11:59AM again", 11, 59, 0, 6, 1, 1, 0);
        run_rows(30, 30);

        // Two ticks into a minute, then an alarm edit, then reset between clock edges.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_all("pre-reset edit", 12, 0, 1, 6, 2, 1, 0);
        i_set_alarm = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_all("async reset", 12, 0, 0, 6, 0, 0, 0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        i_set_alarm = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("post-reset 3 ticks", 12, 0, 0, 6, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("post-reset 4 ticks", 12, 1, 0, 6, 0, 0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post-reset min_tick drop", int'(o_min_tick), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
